// File: rtl/dpll_pkg.sv
// Shared types and saturation helpers for the DPLL loop filter.
// Helpers work on 64-bit signed values and take the target width.
package dpll_pkg;

    typedef enum logic [1:0] {
        P_ONLY  = 2'd0,
        PI      = 2'd1,
        PI_POLE = 2'd2
    } mode_e;

    typedef enum logic {
        G_ACQ = 1'b0,
        G_TRK = 1'b1
    } gear_e;

    // Reserved encoding 3 behaves as plain PI.
    function automatic mode_e decode_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'd0:    r = P_ONLY;
            2'd2:    r = PI_POLE;
            default: r = PI;
        endcase
        return r;
    endfunction

    // Clamp v into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // Clamp v into the unsigned range of a w-bit word.
    function automatic logic [63:0] clamp_unsigned(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        hi = (64'sd1 <<< w) - 64'sd1;
        if (v < 64'sd0) begin
            return '0;
        end
        if (v > hi) begin
            return $unsigned(hi);
        end
        return $unsigned(v);
    endfunction

endpackage

// File: rtl/dpll_sat_accum.sv
// Saturating signed adder: a + b clamped to W bits, never wraps.
// ovf_o flags that the true sum did not fit and was clamped.
module dpll_sat_accum
    import dpll_pkg::*;
#(
    parameter int W = 20
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                ovf_o
);

    logic signed [W:0] raw;

    // One guard bit; overflow when the two top bits disagree.
    always_comb begin
        raw   = {a_i[W-1], a_i} + {b_i[W-1], b_i};
        ovf_o = raw[W] ^ raw[W-1];
        if (ovf_o) begin
            sum_o = raw[W] ? {1'b1, {(W-1){1'b0}}}
                           : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum_o = raw[W-1:0];
        end
    end

endmodule

// File: rtl/dpll_loop_filter.sv
// Digital PI loop filter with optional IIR pole for the DPLL.
// Pipeline: stage 1 (PI sum), stage 2 (pole), output code register.
module dpll_loop_filter
    import dpll_pkg::*;
#(
    parameter int W_ERR   = 8,
    parameter int FRAC    = 8,
    parameter int W_INT   = 20,
    parameter int W_OUT   = 10,
    parameter int ACQ_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    err_valid,
    input  logic signed [W_ERR-1:0] err,
    input  logic [1:0]              mode,
    input  logic [3:0]              kp_acq,
    input  logic [3:0]              ki_acq,
    input  logic [3:0]              kp_trk,
    input  logic [3:0]              ki_trk,
    input  logic [2:0]              kpole,
    input  logic                    freeze,
    input  logic                    init_load,
    input  logic [W_OUT-1:0]        init_code,
    output logic                    out_valid,
    output logic [W_OUT-1:0]        dco_code,
    output logic                    int_sat,
    output logic                    gear
);

    localparam int CW = $clog2(ACQ_LEN + 1);
    localparam logic [CW-1:0] ACQ_END = CW'(ACQ_LEN);
    localparam logic [W_OUT-1:0] CODE_MID = {1'b1, {(W_OUT-1){1'b0}}};
    localparam logic signed [63:0] MID64 = 64'sd1 <<< (W_OUT - 1);
    localparam logic signed [63:0] RND64 = 64'sd1 <<< (FRAC - 1);

    // Sample acceptance; preload outranks freeze, freeze outranks data.
    logic accept;
    assign accept = err_valid & ~freeze & ~init_load;

    // Gear state and accepted-sample counter.
    gear_e           gear_q;
    logic [CW-1:0]   cnt_q;

    // Stage-1 datapath.
    mode_e                   mode_s;
    logic [3:0]              kp_s;
    logic [3:0]              ki_s;
    logic signed [W_INT-1:0] e_s;
    logic signed [W_INT-1:0] prop_s;
    logic signed [W_INT-1:0] iinc_s;
    logic signed [W_INT-1:0] integ_sum;
    logic                    integ_ovf;
    logic signed [W_INT-1:0] integ_d;
    logic                    sat_d;
    logic signed [W_INT-1:0] sum_d;
    logic                    sum_ovf_unused;

    logic signed [W_INT-1:0] integ_q;
    logic signed [W_INT-1:0] sum_q;
    logic                    int_sat_q;
    logic                    v1_q;
    logic                    pole_q;
    logic [2:0]              kpole_q;

    // Stage-2 datapath.
    logic signed [W_INT:0]   diff_s;
    logic signed [W_INT:0]   step_s;
    logic signed [63:0]      y64_s;
    logic signed [63:0]      step64_s;
    logic signed [W_INT-1:0] y_d;
    logic signed [W_INT-1:0] y_q;
    logic                    v2_q;

    // Output stage.
    logic signed [63:0]      rnd_s;
    logic [W_OUT-1:0]        code_d;
    logic [W_OUT-1:0]        code_q;
    logic                    out_valid_q;

    // Preload value in the internal fixed-point domain.
    logic signed [W_OUT:0]   pre_c;
    logic signed [W_INT-1:0] preload_s;

    assign pre_c = $signed({1'b0, init_code}) - $signed({1'b0, CODE_MID});
    assign preload_s = W_INT'(pre_c) <<< FRAC;

    assign e_s = {{(W_INT-W_ERR-FRAC){err[W_ERR-1]}}, err, {FRAC{1'b0}}};

    // Gain selection and PI arithmetic for the incoming sample.
    always_comb begin
        mode_s  = decode_mode(mode);
        kp_s    = (gear_q == G_TRK) ? kp_trk : kp_acq;
        ki_s    = (gear_q == G_TRK) ? ki_trk : ki_acq;
        prop_s  = e_s >>> kp_s;
        iinc_s  = e_s >>> ki_s;
        integ_d = integ_sum;
        sat_d   = integ_ovf;
        if (mode_s == P_ONLY) begin
            integ_d = '0;
            sat_d   = 1'b0;
        end
    end

    dpll_sat_accum #(.W(W_INT)) u_integ (
        .a_i   (integ_q),
        .b_i   (iinc_s),
        .sum_o (integ_sum),
        .ovf_o (integ_ovf)
    );

    dpll_sat_accum #(.W(W_INT)) u_sum (
        .a_i   (integ_d),
        .b_i   (prop_s),
        .sum_o (sum_d),
        .ovf_o (sum_ovf_unused)
    );

    // Pole step toward sum; the result always lies between y and sum.
    always_comb begin
        diff_s   = {sum_q[W_INT-1], sum_q} - {y_q[W_INT-1], y_q};
        step_s   = diff_s >>> kpole_q;
        y64_s    = {{(64-W_INT){y_q[W_INT-1]}}, y_q};
        step64_s = {{(63-W_INT){step_s[W_INT]}}, step_s};
        y_d      = sum_q;
        if (pole_q) begin
            y_d = W_INT'(sat_signed(y64_s + step64_s, W_INT));
        end
    end

    // Round to nearest integer code, recentre, clamp to DCO range.
    always_comb begin
        rnd_s  = ((y64_s + RND64) >>> FRAC) + MID64;
        code_d = W_OUT'(clamp_unsigned(rnd_s, W_OUT));
    end

    // Stage 1: integrator update and PI sum on accepted samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q      <= 1'b0;
            integ_q   <= '0;
            sum_q     <= '0;
            int_sat_q <= 1'b0;
            pole_q    <= 1'b0;
            kpole_q   <= '0;
        end else if (init_load) begin
            v1_q      <= 1'b0;
            integ_q   <= preload_s;
            int_sat_q <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                integ_q   <= integ_d;
                sum_q     <= sum_d;
                int_sat_q <= sat_d;
                pole_q    <= (mode_s == PI_POLE) && (kpole != 3'd0);
                kpole_q   <= kpole;
            end
        end
    end

    // Stage 2: optional first-order pole; drains even while frozen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q <= 1'b0;
            y_q  <= '0;
        end else if (init_load) begin
            v2_q <= 1'b0;
            y_q  <= preload_s;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                y_q <= y_d;
            end
        end
    end

    // Output register: code and one-cycle valid pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_q      <= CODE_MID;
            out_valid_q <= 1'b0;
        end else if (init_load) begin
            code_q      <= init_code;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                code_q <= code_d;
            end
        end
    end

    // Gear FSM: acquisition until ACQ_LEN accepted samples, then tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gear_q <= G_ACQ;
            cnt_q  <= '0;
        end else if (init_load) begin
            gear_q <= G_ACQ;
            cnt_q  <= '0;
        end else if (accept && gear_q == G_ACQ) begin
            cnt_q <= CW'(cnt_q + 1'b1);
            if (CW'(cnt_q + 1'b1) == ACQ_END) begin
                gear_q <= G_TRK;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dco_code  = code_q;
    assign int_sat   = int_sat_q;
    assign gear      = gear_q;

endmodule

// File: tb/tb_dpll_loop_filter.sv
// Directed-vector bench for dpll_loop_filter.
// Inputs change and outputs are sampled on the falling edge.
module tb_dpll_loop_filter;

    logic              clk = 1'b0;
    logic              rstn;
    logic              err_valid;
    logic signed [7:0] err;
    logic [1:0]        mode;
    logic [3:0]        kp_acq;
    logic [3:0]        ki_acq;
    logic [3:0]        kp_trk;
    logic [3:0]        ki_trk;
    logic [2:0]        kpole;
    logic              freeze;
    logic              init_load;
    logic [9:0]        init_code;
    logic              out_valid;
    logic [9:0]        dco_code;
    logic              int_sat;
    logic              gear;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dpll_loop_filter #(
        .W_ERR   (8),
        .FRAC    (8),
        .W_INT   (20),
        .W_OUT   (10),
        .ACQ_LEN (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .err_valid (err_valid),
        .err       (err),
        .mode      (mode),
        .kp_acq    (kp_acq),
        .ki_acq    (ki_acq),
        .kp_trk    (kp_trk),
        .ki_trk    (ki_trk),
        .kpole     (kpole),
        .freeze    (freeze),
        .init_load (init_load),
        .init_code (init_code),
        .out_valid (out_valid),
        .dco_code  (dco_code),
        .int_sat   (int_sat),
        .gear      (gear)
    );

    task automatic idle_inputs();
        err_valid = 1'b0;
        err       = 8'sd0;
        mode      = 2'd1;
        kp_acq    = 4'd0;
        ki_acq    = 4'd0;
        kp_trk    = 4'd0;
        ki_trk    = 4'd0;
        kpole     = 3'd0;
        freeze    = 1'b0;
        init_load = 1'b0;
        init_code = 10'd512;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dco_code !== 10'd512) begin
            n_bad++;
            $display("FAIL reset_code got %0d exp 512", dco_code);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid got %b exp 0", out_valid);
        end
        n_cmp++;
        if (int_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_sat got %b exp 0", int_sat);
        end
        n_cmp++;
        if (gear !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_gear got %b exp 0", gear);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pi_impulse();
        apply_reset();
        mode      = 2'd1;
        kp_acq    = 4'd2;
        ki_acq    = 4'd4;
        err       = 8'sd16;
        err_valid = 1'b1;
        @(negedge clk);
        err = 8'sd0;
        @(negedge clk);
        err_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dco_code !== 10'd517 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pi_first got %0d/%b exp 517/1", dco_code, out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (dco_code !== 10'd513 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pi_second got %0d/%b exp 513/1", dco_code, out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL pi_pulse got %b exp 0", out_valid);
        end
    endtask

    task automatic test_gear_shift();
        logic [9:0] exp_code;
        apply_reset();
        mode      = 2'd0;
        kp_acq    = 4'd1;
        kp_trk    = 4'd4;
        ki_acq    = 4'd3;
        ki_trk    = 4'd3;
        err       = 8'sd8;
        err_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 6) err_valid = 1'b0;
            if (c >= 3 && c <= 8) begin
                exp_code = (c - 2 <= 4) ? 10'd516 : 10'd513;
                n_cmp++;
                if (dco_code !== exp_code || out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL gear_code[%0d] got %0d/%b exp %0d/1",
                             c, dco_code, out_valid, exp_code);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (gear !== 1'b0) begin
                    n_bad++;
                    $display("FAIL gear_early got %b exp 0", gear);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (gear !== 1'b1) begin
                    n_bad++;
                    $display("FAIL gear_rise got %b exp 1", gear);
                end
            end
            if (c == 9) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL gear_end_valid got %b exp 0", out_valid);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int prev;
        int drops;
        apply_reset();
        mode      = 2'd1;
        err       = 8'sd127;
        err_valid = 1'b1;
        prev      = 512;
        drops     = 0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            if (int'(dco_code) < prev) drops++;
            prev = int'(dco_code);
        end
        n_cmp++;
        if (drops != 0) begin
            n_bad++;
            $display("FAIL sat_wrap got %0d drops exp 0", drops);
        end
        n_cmp++;
        if (dco_code !== 10'd1023) begin
            n_bad++;
            $display("FAIL sat_code got %0d exp 1023", dco_code);
        end
        n_cmp++;
        if (int_sat !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_flag got %b exp 1", int_sat);
        end
        n_cmp++;
        if (dut.integ_q !== 20'sd524287) begin
            n_bad++;
            $display("FAIL sat_integ got %0d exp 524287", dut.integ_q);
        end
        err = -8'sd128;
        @(negedge clk);
        err_valid = 1'b0;
        n_cmp++;
        if (int_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_clear got %b exp 0", int_sat);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dco_code !== 10'd1023) begin
            n_bad++;
            $display("FAIL sat_after got %0d exp 1023", dco_code);
        end
    endtask

    task automatic test_freeze();
        apply_reset();
        mode      = 2'd1;
        kp_acq    = 4'd2;
        ki_acq    = 4'd4;
        kp_trk    = 4'd2;
        ki_trk    = 4'd4;
        err       = 8'sd16;
        err_valid = 1'b1;
        repeat (5) @(negedge clk);
        freeze = 1'b1;
        for (int c = 6; c <= 15; c++) begin
            @(negedge clk);
            if (c == 7) begin
                n_cmp++;
                if (dco_code !== 10'd521 || out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL frz_drain got %0d/%b exp 521/1",
                             dco_code, out_valid);
                end
            end
            if (c >= 8) begin
                n_cmp++;
                if (dco_code !== 10'd521 || out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL frz_hold[%0d] got %0d/%b exp 521/0",
                             c, dco_code, out_valid);
                end
            end
        end
        n_cmp++;
        if (gear !== 1'b1) begin
            n_bad++;
            $display("FAIL frz_gear got %b exp 1", gear);
        end
        init_load = 1'b1;
        init_code = 10'd300;
        @(negedge clk);
        n_cmp++;
        if (dco_code !== 10'd300 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL preload_code got %0d/%b exp 300/1",
                     dco_code, out_valid);
        end
        n_cmp++;
        if (gear !== 1'b0) begin
            n_bad++;
            $display("FAIL preload_gear got %b exp 0", gear);
        end
        init_load = 1'b0;
        freeze    = 1'b0;
        err_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dco_code !== 10'd300 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL preload_after got %0d/%b exp 300/0",
                     dco_code, out_valid);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        mode      = 2'd1;
        kp_acq    = 4'd2;
        ki_acq    = 4'd4;
        err       = 8'sd16;
        err_valid = 1'b1;
        @(negedge clk);
        err_valid = 1'b0;
        init_load = 1'b1;
        init_code = 10'd400;
        @(negedge clk);
        init_load = 1'b0;
        n_cmp++;
        if (dco_code !== 10'd400 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_load got %0d/%b exp 400/1",
                     dco_code, out_valid);
        end
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (dco_code !== 10'd400 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_drop got %0d/%b exp 400/0",
                         dco_code, out_valid);
            end
        end
    endtask

    task automatic test_pole_and_reset();
        logic [9:0] exp_code;
        apply_reset();
        mode      = 2'd2;
        kpole     = 3'd1;
        kp_acq    = 4'd0;
        kp_trk    = 4'd0;
        ki_acq    = 4'd15;
        ki_trk    = 4'd15;
        init_load = 1'b1;
        init_code = 10'd512;
        @(negedge clk);
        init_load = 1'b0;
        err       = 8'sd10;
        err_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL pole_lat got %b exp 0", out_valid);
                end
            end
            if (c >= 3 && c <= 5) begin
                exp_code = (c == 3) ? 10'd517 : (c == 4) ? 10'd520 : 10'd521;
                n_cmp++;
                if (dco_code !== exp_code || out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL pole_code[%0d] got %0d/%b exp %0d/1",
                             c, dco_code, out_valid, exp_code);
                end
            end
        end
        #1;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (dco_code !== 10'd512 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst got %0d/%b exp 512/0", dco_code, out_valid);
        end
        #1;
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_lat1 got %b exp 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_lat2 got %b exp 0", out_valid);
        end
        @(negedge clk);
        err_valid = 1'b0;
        n_cmp++;
        if (dco_code !== 10'd517 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_first got %0d/%b exp 517/1", dco_code, out_valid);
        end
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        test_reset();
        test_pi_impulse();
        test_gear_shift();
        test_saturation();
        test_freeze();
        test_flush();
        test_pole_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
